// File: rtl/mac_timestep_scheduler.sv
// -----------------------------------------------------------------------------
// mac_timestep_scheduler
//
// Shared timestep controller for an array of MAC units. A run proceeds as
// follows:
//   1. mac_set is held high for INIT_CYCLES cycles.
//   2. Each timestep has a dispatch window of DISPATCH_CYCLES cycles. In that
//      window, buffered spike addresses are broadcast on mac_source_address.
//   3. The timestep closes with a clear/done handshake (CLEAR, then RELEASE).
// Spikes are buffered in a FIFO. A spike that arrives while no window is open
// waits for the next window. Entries left in the FIFO at the end of a window
// are carried over to the next one.
//
// Ports
//   CLK, RESETn         clock (rising edge), asynchronous active-low reset
//   start               one-cycle run request; ignored while busy
//   num_timesteps       timesteps in the run, sampled on start
//   spike_valid/addr    incoming spike; accepted when spike_ready is high
//   spike_ready         busy and FIFO not full
//   mac_source_address  address broadcast to all units (all-ones = none)
//   mac_set, mac_clear  initialisation / end-of-timestep levels to the units
//   mac_done            per-unit done flags
//   busy                run in progress (from the cycle after start to DONE)
//   run_done            one-cycle pulse at the end of a run
//   timestep_count      completed timesteps in the current run
//   timeout_err         sticky done-wait timeout flag
//
// Optional feature: define SCHED_DONE_TIMEOUT_EN to bound the CLEAR and
// RELEASE waits to TIMEOUT_CYCLES each. When the macro is undefined, these
// waits are unbounded and timeout_err is tied to 0.
// -----------------------------------------------------------------------------
module mac_timestep_scheduler #(
  parameter int NUM_UNITS       = 10,
  parameter int ADDR_W          = 12,
  parameter int FIFO_DEPTH      = 8,
  parameter int DISPATCH_CYCLES = 64,
  parameter int INIT_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 start,
  input  logic [15:0]          num_timesteps,
  input  logic                 spike_valid,
  input  logic [ADDR_W-1:0]    spike_addr,
  output logic                 spike_ready,
  output logic [ADDR_W-1:0]    mac_source_address,
  output logic                 mac_set,
  output logic                 mac_clear,
  input  logic [NUM_UNITS-1:0] mac_done,
  output logic                 busy,
  output logic                 run_done,
  output logic [15:0]          timestep_count,
  output logic                 timeout_err
);

  // All-ones never matches a real MAC source address.
  localparam logic [ADDR_W-1:0] NULL_ADDR = '1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WIN_W  = $clog2(DISPATCH_CYCLES) + 1;
  localparam int INIT_W = $clog2(INIT_CYCLES) + 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INIT     = 3'd1;
  localparam logic [2:0] S_DISPATCH = 3'd2;
  localparam logic [2:0] S_CLEAR    = 3'd3;
  localparam logic [2:0] S_RELEASE  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]        state;
  logic [15:0]       target;
  logic [WIN_W-1:0]  win_cnt;
  logic [INIT_W-1:0] init_cnt;

  logic [ADDR_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic              fifo_empty, fifo_full;
  logic              push, pop, last_spike;
  logic              clear_hs, release_hs, clear_go, release_go;

  assign fifo_empty  = (fifo_cnt == '0);
  assign fifo_full   = (fifo_cnt == (PTR_W+1)'(FIFO_DEPTH));
  assign busy        = (state != S_IDLE);
  assign mac_set     = (state == S_INIT);
  assign mac_clear   = (state == S_CLEAR);
  assign spike_ready = busy && !fifo_full;
  // A NULL_ADDR spike completes the handshake but is never stored.
  assign push        = spike_valid && spike_ready && (spike_addr != NULL_ADDR);
  // Skipping the cycle after each spike forces an address change. This lets
  // a repeated address re-trigger the level-sensitive MAC units.
  assign pop         = (state == S_DISPATCH) && !fifo_empty && !last_spike;
  // The FIFO head is driven combinationally, so a spike pushed into an empty
  // FIFO during a window is broadcast one cycle later.
  assign mac_source_address = pop ? fifo_mem[rd_ptr] : NULL_ADDR;

  assign clear_hs   = &mac_done;
  assign release_hs = ~|mac_done;

`ifdef SCHED_DONE_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WAIT_W-1:0] wait_cnt;
  logic              in_wait, wait_expired, wait_advance;

  assign in_wait      = (state == S_CLEAR) || (state == S_RELEASE);
  assign wait_expired = in_wait && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign clear_go     = clear_hs || wait_expired;
  assign release_go   = release_hs || wait_expired;
  assign wait_advance = ((state == S_CLEAR) && clear_go) ||
                        ((state == S_RELEASE) && release_go);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      // The count restarts on every state change, so CLEAR and RELEASE each
      // get the full budget.
      if (in_wait && !wait_advance) wait_cnt <= wait_cnt + 1'b1;
      else                          wait_cnt <= '0;
      if ((state == S_IDLE) && start)
        timeout_err <= 1'b0;
      else if (((state == S_CLEAR) && !clear_hs && wait_expired) ||
               ((state == S_RELEASE) && !release_hs && wait_expired))
        timeout_err <= 1'b1;
    end
  end
`else
  assign clear_go    = clear_hs;
  assign release_go  = release_hs;
  assign timeout_err = 1'b0;
`endif

  // NOTE: the storage array has no reset. Emptiness is tracked only by the
  // pointers and the count, so the stale contents are never observed.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= spike_addr;
  end

  // NOTE: every sequential block uses non-blocking assignments only, so all
  // registers sample the same pre-edge values.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      last_spike <= 1'b0;
    end else if (state == S_DONE) begin
      // The run has ended; any residue belongs to no timestep.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      last_spike <= 1'b0;
    end else begin
      last_spike <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state          <= S_IDLE;
      target         <= '0;
      timestep_count <= '0;
      win_cnt        <= '0;
      init_cnt       <= '0;
      run_done       <= 1'b0;
    end else begin
      run_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (num_timesteps == 16'd0) begin
              run_done <= 1'b1;
            end else begin
              target         <= num_timesteps;
              timestep_count <= '0;
              init_cnt       <= '0;
              state          <= S_INIT;
            end
          end
        end
        S_INIT: begin
          if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
            win_cnt <= '0;
            state   <= S_DISPATCH;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        S_DISPATCH: begin
          if (win_cnt == WIN_W'(DISPATCH_CYCLES - 1)) state <= S_CLEAR;
          else                                       win_cnt <= win_cnt + 1'b1;
        end
        S_CLEAR: begin
          if (clear_go) state <= S_RELEASE;
        end
        S_RELEASE: begin
          if (release_go) begin
            timestep_count <= timestep_count + 16'd1;
            if (timestep_count + 16'd1 == target) begin
              run_done <= 1'b1;
              state    <= S_DONE;
            end else begin
              win_cnt <= '0;
              state   <= S_DISPATCH;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
